// File: rtl/lsu_wb_queue_if.sv
// lsu_wb_queue_if: RMW write, scheduler load and memory bus signals of the LSU writeback queue.
interface lsu_wb_queue_if #(parameter int DEPTH = 4);
  logic                     rmw_data_rdy;
  logic [15:0]              rmw_addr;
  logic [15:0]              rmw_data;
  logic                     rmw_deny_op;
  logic                     rmw_hold;
  logic                     ld_req;
  logic [15:0]              ld_addr;
  logic                     ld_done;
  logic [15:0]              ld_data;
  logic [$clog2(DEPTH):0]   wb_count;
  logic                     mem_req;
  logic                     mem_we;
  logic [15:0]              mem_addr;
  logic [15:0]              mem_data_out;
  logic                     mem_rdy;
  logic [15:0]              mem_data_in;
  modport slave (
    input  rmw_data_rdy, rmw_addr, rmw_data, rmw_deny_op, ld_req, ld_addr, mem_rdy, mem_data_in,
    output rmw_hold, ld_done, ld_data, wb_count, mem_req, mem_we, mem_addr, mem_data_out
  );
  modport master (
    output rmw_data_rdy, rmw_addr, rmw_data, rmw_deny_op, ld_req, ld_addr, mem_rdy, mem_data_in,
    input  rmw_hold, ld_done, ld_data, wb_count, mem_req, mem_we, mem_addr, mem_data_out
  );
endinterface

// File: rtl/lsu_wb_queue.sv
// lsu_wb_queue: RMW write FIFO plus load/store arbiter for one memory port.
// Define WB_FORWARD_EN to serve FIFO-hit loads from the youngest matching entry.
module lsu_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 4
) (
  input logic           clk,
  input logic           a_rst_n,
  lsu_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = 1 << AW;
  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic full, empty, push, pop, fifo_hit, bypass, hazard, ld_go, fwd, start_ld, start_st;
`ifdef WB_FORWARD_EN
  logic [DW-1:0] fwd_data;
`endif
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign push  = bus.rmw_data_rdy & ~full;
  assign pop   = (state == STORE) & bus.mem_rdy;
  assign bus.rmw_hold = bus.rmw_data_rdy & full;
  assign bus.wb_count = count;
  assign bypass = bus.rmw_data_rdy & (bus.ld_addr == bus.rmw_addr);
  assign hazard = bus.rmw_deny_op | fifo_hit | bypass;
  // ld_req is still high during the ld_done cycle; don't restart that load
  assign ld_go  = bus.ld_req & ~bus.ld_done;
`ifdef WB_FORWARD_EN
  assign fwd = (state == IDLE) & ld_go & fifo_hit & ~bus.rmw_deny_op & ~bypass;
`else
  assign fwd = 1'b0;
`endif
  // scan oldest to youngest so the youngest match wins
  always_comb begin
    fifo_hit = 1'b0;
`ifdef WB_FORWARD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < count && fifo_addr[rd_ptr + PW'(k)] == bus.ld_addr) begin
        fifo_hit = 1'b1;
`ifdef WB_FORWARD_EN
        fwd_data = fifo_data[rd_ptr + PW'(k)];
`endif
      end
    end
  end
  always_comb begin
    state_nx = state;
    start_ld = 1'b0;
    start_st = 1'b0;
    if (state == IDLE) begin
      if (ld_go && !hazard && !full) begin
        state_nx = LOAD;
        start_ld = 1'b1;
      end else if (!fwd && !empty) begin
        state_nx = STORE;
        start_st = 1'b1;
      end
    end else if (bus.mem_rdy) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.rmw_addr;
      fifo_data[wr_ptr] <= bus.rmw_data;
    end
  end
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_data_out <= '0;
      bus.ld_done      <= 1'b0;
      bus.ld_data      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      bus.ld_done <= ((state == LOAD) & bus.mem_rdy) | fwd;
      if (state == LOAD && bus.mem_rdy) bus.ld_data <= bus.mem_data_in;
`ifdef WB_FORWARD_EN
      else if (fwd) bus.ld_data <= fwd_data;
`endif
      if (start_ld) begin
        bus.mem_req      <= 1'b1;
        bus.mem_we       <= 1'b0;
        bus.mem_addr     <= bus.ld_addr;
        bus.mem_data_out <= '0;
      end else if (start_st) begin
        bus.mem_req      <= 1'b1;
        bus.mem_we       <= 1'b1;
        bus.mem_addr     <= fifo_addr[rd_ptr];
        bus.mem_data_out <= fifo_data[rd_ptr];
      end else if (state != IDLE && bus.mem_rdy) bus.mem_req <= 1'b0;
    end
  end
endmodule
